hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/div_step.sv | 27 ++
 rtl/hilo_div_ctrl.sv | 138 +++++++++++++
 tb/tb_hilo_div_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// ============================================================================
// Module  : hilo_pkg
// Purpose : Shared types and constants for the HI/LO divider controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          DIV_ITERS  = 32;
    localparam logic [5:0]  FUNCT_DIV  = 6'h1A;
    localparam logic [5:0]  FUNCT_DIVU = 6'h1B;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational radix-2 restoring division step on {rem, quot}.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step (
    input  logic [63:0] i_pair,
    input  logic [31:0] i_divisor,
    output logic [63:0] o_pair
);

    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // The remainder stays below the divisor, so the shifted value fits 33 bits
    // and a borrow out of bit 32 means the trial subtraction failed.
    assign w_rem_sh = i_pair[63:31];
    assign w_diff   = w_rem_sh - {1'b0, i_divisor};

    assign o_pair = w_diff[32] ? {w_rem_sh[31:0], i_pair[30:0], 1'b0}
                               : {w_diff[31:0],   i_pair[30:0], 1'b1};

endmodule

`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
// ============================================================================
// Module  : hilo_div_ctrl
// Purpose : Multi-cycle DIV/DIVU unit driving HI/LO with pipeline stall.
//           Optional macro DIV_ZERO_FAST_EN: divide-by-zero finishes in 2 cycles.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_div_ctrl
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] C_LAST_ITER = 6'(DIV_ITERS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic [5:0]  r_cnt;
    logic [63:0] r_pair;
    logic [63:0] w_pair_nxt;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_sign_a = signed_div & opa[31];
    assign w_sign_b = signed_div & opb[31];
    assign w_abs_a  = w_sign_a ? (~opa + 32'd1) : opa;
    assign w_abs_b  = w_sign_b ? (~opb + 32'd1) : opb;

    div_step u_div_step (
        .i_pair    (r_pair),
        .i_divisor (r_divisor),
        .o_pair    (w_pair_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rst gates the accept so stall reads 0 while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush && rst) begin
                    w_accept = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    w_state_nxt = (opb == 32'd0) ? ST_DONE : ST_BUSY;
`else
                    w_state_nxt = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                if (r_cnt == C_LAST_ITER) begin
                    w_state_nxt = ST_SIGN;
                end
            end
            ST_SIGN: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign stall        = w_accept || (r_state == ST_BUSY) || (r_state == ST_SIGN);
    assign result_valid = (r_state == ST_DONE) && !flush;
    assign hi           = r_hi;
    assign lo           = r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 6'd0;
            r_pair    <= 64'd0;
            r_divisor <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else if (w_accept) begin
            r_pair    <= {32'd0, w_abs_a};
            r_divisor <= w_abs_b;
            r_neg_q   <= w_sign_a ^ w_sign_b;
            r_neg_r   <= w_sign_a;
            r_div0    <= (opb == 32'd0);
            r_cnt     <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
            if (opb == 32'd0) begin
                r_hi <= opa;
                r_lo <= DIV0_QUOT;
            end
`endif
        end else if (r_state == ST_BUSY && !flush) begin
            r_pair <= w_pair_nxt;
            r_cnt  <= r_cnt + 6'd1;
        end else if (r_state == ST_SIGN && !flush) begin
            // Divide-by-zero leaves |opa| as remainder; the remainder sign
            // fix restores opa, but the quotient must be forced to all ones.
            r_hi <= r_neg_r ? (~r_pair[63:32] + 32'd1) : r_pair[63:32];
            if (r_div0) begin
                r_lo <= DIV0_QUOT;
            end else begin
                r_lo <= r_neg_q ? (~r_pair[31:0] + 32'd1) : r_pair[31:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
// ============================================================================
// Module  : tb_hilo_div_ctrl
// Purpose : Self-checking bench for hilo_div_ctrl against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    hilo_div_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Quotient/remainder straight from the divide rules, using language arithmetic.
    function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sd) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 2 : 35;
`else
        return (b == 32'd0) ? 35 : 35;
`endif
    endfunction

    task automatic do_div(input string tag, input logic sd, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        bit          got;
        int          lat;
        logic [31:0] eq;
        logic [31:0] er;
        model(sd, a, b, eq, er);
        lat = exp_latency(b);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        opa        = a;
        opb        = b;
        #1 check({tag, "_stall_start"}, 64'(stall), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (result_valid) begin
                got = 1'b1;
            end else if (cyc < lat) begin
                check({tag, "_stall_busy"}, 64'(stall), 64'd1);
            end
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(er));
        check({tag, "_lo"}, 64'(lo), 64'(eq));
        @(negedge clk);
        check({tag, "_rv_after"}, 64'(result_valid), 64'd0);
        check({tag, "_hi_hold"}, 64'(hi), 64'(er));
        check({tag, "_lo_hold"}, 64'(lo), 64'(eq));
        prev_hi = er;
        prev_lo = eq;
    endtask

    initial begin
        int          pulses[$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rsd;
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        opa        = 32'd0;
        opb        = 32'd0;
        flush      = 1'b0;
        prev_hi    = 32'd0;
        prev_lo    = 32'd0;

        repeat (2) @(negedge clk);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_rv", 64'(result_valid), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b1;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        do_div("div_neg_0", 1'b1, 32'hFFFF_FFF0, 32'd0);

        // Flush in BUSY cycle 10.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_rv", 64'(result_valid), 64'd0);
        check("flush_hi", 64'(hi), 64'(prev_hi));
        check("flush_lo", 64'(lo), 64'(prev_lo));
        @(negedge clk);
        check("flush_idle_rv", 64'(result_valid), 64'd0);
        check("flush_idle_stall", 64'(stall), 64'd0);
        do_div("after_flush", 1'b0, 32'd1000, 32'd3);

        // Reset in BUSY cycle 20.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b1; opa = 32'h1234_5678; opb = 32'd17;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_rv", 64'(result_valid), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // start held high across more than one operation.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd7;
        for (int c = 1; c <= 110; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (result_valid) pulses.push_back(c);
            if (c == 69) start = 1'b0;
        end
        check("hold_pulses", 64'(pulses.size()), 64'd2);
        if (pulses.size() >= 2) begin
            check("hold_first", 64'(pulses[0]), 64'd35);
            check("hold_second", 64'(pulses[1]), 64'd70);
        end
        check("hold_hi", 64'(hi), 64'd6);
        check("hold_lo", 64'(lo), 64'd142);

        // Randomized operands, with zero and small divisors mixed in.
        for (int n = 0; n < 20; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rsd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_div("rand", rsd, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
